// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INST_RD = 2'd1,
    ST_DATA_RD = 2'd2,
    ST_DATA_WR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LEN_B  = 2'b00,
    LEN_H  = 2'b01,
    LEN_W  = 2'b10,
    LEN_W2 = 2'b11
  } len_e;

  localparam logic [1:0]  IO_SEL    = 2'b11;
  localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len_e'(len))
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_assembler.sv
// Byte-lane capture register for serial reads; zero-extends the word to the request length.
module mem_arbiter_rd_assembler #(
  parameter int NUM_LANES = 4,
  localparam int LW = $clog2(NUM_LANES),
  localparam int NW = $clog2(NUM_LANES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cap_en_i,
  input  logic [LW-1:0]              lane_i,
  input  logic [7:0]                 din_i,
  input  logic [NW-1:0]              n_i,
  output logic [NUM_LANES-1:0][7:0]  word_o,
  output logic [NUM_LANES-1:0][7:0]  zext_o
);

  logic [NUM_LANES-1:0][7:0] lane_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)       lane_q <= '0;
    else if (cap_en_i) lane_q[lane_i] <= din_i;
  end

  assign word_o = lane_q;

  // Lanes above the request length may hold stale bytes from an earlier access.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign zext_o[g] = (NW'(g) < n_i) ? lane_q[g] : 8'h00;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial bus sequencer: arbitrates fetch vs data port onto one byte-wide RAM/IO bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_flush,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_len,
  input  logic [31:0]       data_wdata,
  output logic              data_valid,
  output logic [31:0]       data_rdata,
  output logic              busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr
);

  state_e            state_q, state_d;
  logic [2:0]        issue_q, issue_d, got_q, got_d, n_q, n_d, issue_eff;
  logic [ADDR_W-1:0] base_q, base_d, cur_a;
  logic [3:0][7:0]   wdata_q, wdata_d;
  logic [31:0]       a_q, a_d;
  logic [7:0]        dout_q, dout_d, cur_byte;
  logic              resume_q, resume_d;
  logic              is_rd, kill, run, done, issuing, capture, free, take_data, take_inst;

  assign is_rd = (state_q == ST_INST_RD) || (state_q == ST_DATA_RD);
  assign kill  = (state_q == ST_INST_RD) && inst_flush;
  assign run   = rdy_in && !kill;

  // After a pause the byte in flight was never captured, so re-present it.
  assign issue_eff = (is_rd && resume_q) ? got_q : issue_q;
  assign cur_a     = base_q + ADDR_W'(issue_eff);
  assign cur_byte  = wdata_q[issue_eff[1:0]];

  assign done    = run && ((is_rd && got_q == n_q) ||
                           (state_q == ST_DATA_WR && issue_q == n_q));
  assign issuing = run && (state_q != ST_IDLE) && (issue_eff < n_q);
  assign capture = run && is_rd && (got_q < issue_eff);

  assign free      = run && (state_q == ST_IDLE || done);
  assign take_data = free && data_req;
  assign take_inst = free && !data_req && inst_req && !inst_flush;

  always_comb begin
    state_d  = state_q;
    issue_d  = issue_q;
    got_d    = got_q;
    n_d      = n_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    a_d      = a_q;
    dout_d   = dout_q;
    resume_d = !rdy_in;
    if (run) begin
      issue_d = issue_eff + {2'b00, issuing};
      got_d   = got_q + {2'b00, capture};
      if (issuing) begin
        a_d    = 32'(cur_a);
        dout_d = cur_byte;
      end
      if (done) state_d = ST_IDLE;
      if (take_data) begin
        state_d = data_wr ? ST_DATA_WR : ST_DATA_RD;
        base_d  = data_addr;
        n_d     = len_to_n(data_len);
        wdata_d = data_wdata;
        issue_d = '0;
        got_d   = '0;
      end else if (take_inst) begin
        state_d = ST_INST_RD;
        base_d  = inst_addr;
        n_d     = 3'd4;
        issue_d = '0;
        got_d   = '0;
      end
    end else if (rdy_in) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      issue_q  <= '0;
      got_q    <= '0;
      n_q      <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      got_q    <= got_d;
      n_q      <= n_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      resume_q <= resume_d;
    end
  end

  mem_arbiter_rd_assembler #(.NUM_LANES(4)) u_asm (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .cap_en_i (capture),
    .lane_i   (got_q[1:0]),
    .din_i    (mem_din),
    .n_i      (n_q),
    .word_o   (inst_data),
    .zext_o   (data_rdata)
  );

  assign mem_a      = issuing ? 32'(cur_a) : a_q;
  assign mem_dout   = issuing ? cur_byte : dout_q;
  assign mem_wr     = issuing && (state_q == ST_DATA_WR);
  assign inst_valid = done && (state_q == ST_INST_RD);
  assign data_valid = done && (state_q != ST_INST_RD);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing sequences, a transaction table, and random traffic vs a byte-array model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        inst_req, inst_flush, inst_valid;
  logic [31:0] inst_addr, inst_data;
  logic        data_req, data_wr, data_valid, busy;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_valid(inst_valid), .inst_data(inst_data),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_len(data_len), .data_wdata(data_wdata),
    .data_valid(data_valid), .data_rdata(data_rdata), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // Synchronous 1 KiB RAM, one-cycle read latency, aliased on mem_a[9:0].
  logic [7:0] ram [1024];
  logic       init_ram = 1'b0, poke_en = 1'b0;
  logic [9:0] poke_a;
  logic [7:0] poke_d;
  always @(posedge clk) begin
    if (init_ram) for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 7 + 3);
    else if (poke_en) ram[poke_a] <= poke_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  int bad_wr = 0;
  always @(negedge clk) if (!rdy_in && mem_wr) bad_wr++;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    next_cyc(); poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1; poke_en = 1'b0;
  endtask

  task automatic do_init_ram();
    next_cyc(); init_ram = 1'b1;
    @(posedge clk); #1; init_ram = 1'b0;
  endtask

  // One request from acceptance cycle T (lat=0) until its valid pulse.
  task automatic run_txn(input bit is_inst, input bit wr, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wd, input bit rnd,
                         output logic [31:0] rd, output int lat, output int pz,
                         output int rn, output bit ok);
    bit prev_low;
    ok = 0; lat = 0; pz = 0; rn = 0; rd = '0; prev_low = 0;
    next_cyc();
    if (is_inst) begin
      inst_req = 1; inst_addr = addr;
    end else begin
      data_req = 1; data_wr = wr; data_addr = addr; data_len = len; data_wdata = wd;
    end
    for (int c = 0; c < 80 && !ok; c++) begin
      if (c > 0) next_cyc();
      rdy_in = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      if (!rdy_in) begin pz++; if (!prev_low) rn++; end
      prev_low = !rdy_in;
      @(negedge clk);
      if (is_inst ? inst_valid : data_valid) begin
        ok = 1; lat = c; rd = is_inst ? inst_data : data_rdata;
        inst_req = 0; data_req = 0;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL txn timeout: addr=%h no valid within 80 cycles", addr);
      inst_req = 0; data_req = 0; rdy_in = 1;
    end
  endtask

  typedef struct {
    bit          is_inst;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t       vt [12];
  logic [7:0] mdl [1024];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, w, expv;
    int lat, pz, rn, vcnt, n, base;
    bit ok, is_inst, wr;
    logic [31:0] addr, wd;
    logic [1:0] len;

    rst_in = 0; rdy_in = 1; inst_req = 0; inst_flush = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_addr = '0; data_len = '0; data_wdata = '0;

    vt[0]  = '{0, 1, 32'h200,      2'b10, 32'hDEADBEEF, 32'h0,        5};
    vt[1]  = '{0, 0, 32'h200,      2'b10, 32'h0,        32'hDEADBEEF, 6};
    vt[2]  = '{0, 0, 32'h201,      2'b01, 32'h0,        32'h0000ADBE, 4};
    vt[3]  = '{0, 0, 32'h203,      2'b00, 32'h0,        32'h000000DE, 3};
    vt[4]  = '{0, 1, 32'h202,      2'b00, 32'h1234565A, 32'h0,        2};
    vt[5]  = '{0, 0, 32'h200,      2'b11, 32'h0,        32'hDE5ABEEF, 6};
    vt[6]  = '{0, 1, 32'h1FF,      2'b01, 32'hFFFFC3A5, 32'h0,        3};
    vt[7]  = '{1, 0, 32'h200,      2'b00, 32'h0,        32'hDE5ABEC3, 6};
    vt[8]  = '{0, 0, 32'h1FF,      2'b01, 32'h0,        32'h0000C3A5, 4};
    vt[9]  = '{0, 1, 32'hFFFFFFFE, 2'b11, 32'h11223344, 32'h0,        5};
    vt[10] = '{0, 0, 32'hFFFFFFFE, 2'b10, 32'h0,        32'h11223344, 6};
    vt[11] = '{0, 0, 32'h3FF,      2'b00, 32'h0,        32'h00000033, 3};

    do_init_ram();
    repeat (3) next_cyc();
    rst_in = 1;
    @(negedge clk);
    chk("reset mem_a", mem_a, 0);       chk("reset mem_dout", {24'h0, mem_dout}, 0);
    chk("reset mem_wr", {31'h0, mem_wr}, 0); chk("reset busy", {31'h0, busy}, 0);
    chk("reset inst_valid", {31'h0, inst_valid}, 0);
    chk("reset data_valid", {31'h0, data_valid}, 0);
    chk("reset inst_data", inst_data, 0); chk("reset data_rdata", data_rdata, 0);

    // A: word fetch at 0x1000
    poke(10'h000, 8'h13); poke(10'h001, 8'h05); poke(10'h002, 8'h10); poke(10'h003, 8'h00);
    next_cyc(); inst_req = 1; inst_addr = 32'h1000;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      next_cyc(); @(negedge clk);
      chk($sformatf("A mem_a T+%0d", k), mem_a, 32'h1000 + k - 1);
    end
    next_cyc(); @(negedge clk); chk("A inst_valid T+5", {31'h0, inst_valid}, 0);
    next_cyc(); @(negedge clk); chk("A inst_valid T+6", {31'h0, inst_valid}, 1);
    chk("A inst_data", inst_data, 32'h00100513);
    inst_req = 0;

    // B: simultaneous store and fetch; store wins, fetch accepted in the store's valid cycle
    w = 32'hDEADBEEF;
    next_cyc(); data_req = 1; data_wr = 1; data_addr = 32'h200; data_len = 2'b10;
    data_wdata = w; inst_req = 1; inst_addr = 32'h1000;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      next_cyc(); @(negedge clk);
      chk($sformatf("B mem_wr T+%0d", k), {31'h0, mem_wr}, 1);
      chk($sformatf("B mem_dout T+%0d", k), {24'h0, mem_dout}, {24'h0, w[8*(k-1) +: 8]});
      chk($sformatf("B mem_a T+%0d", k), mem_a, 32'h200 + k - 1);
    end
    next_cyc(); @(negedge clk); chk("B data_valid T+5", {31'h0, data_valid}, 1);
    data_req = 0;
    next_cyc(); @(negedge clk); chk("B fetch mem_a T+6", mem_a, 32'h1000);
    chk("B mem_wr T+6", {31'h0, mem_wr}, 0);
    repeat (4) next_cyc();
    next_cyc(); @(negedge clk); chk("B inst_valid T+11", {31'h0, inst_valid}, 1);
    chk("B inst_data", inst_data, 32'h00100513);
    inst_req = 0;

    // C: unaligned half load
    poke(10'h301, 8'h80); poke(10'h302, 8'hFF);
    next_cyc(); data_req = 1; data_wr = 0; data_addr = 32'h301; data_len = 2'b01;
    repeat (3) next_cyc();
    @(negedge clk); chk("C data_valid T+3", {31'h0, data_valid}, 0);
    next_cyc(); @(negedge clk); chk("C data_valid T+4", {31'h0, data_valid}, 1);
    chk("C data_rdata", data_rdata, 32'h0000FF80);
    data_req = 0;

    // D: flush in T+3 of a fetch, redirected fetch accepted at T+4
    next_cyc(); inst_req = 1; inst_addr = 32'h1000;
    next_cyc();
    next_cyc(); @(negedge clk); chk("D mem_a T+2", mem_a, 32'h1001);
    next_cyc(); inst_flush = 1; @(negedge clk);
    chk("D mem_a held T+3", mem_a, 32'h1001);
    chk("D inst_valid T+3", {31'h0, inst_valid}, 0);
    next_cyc(); inst_flush = 0; inst_addr = 32'h1040; @(negedge clk);
    chk("D idle T+4", {31'h0, busy}, 0);
    vcnt = 0;
    for (int k = 5; k <= 9; k++) begin
      next_cyc(); @(negedge clk);
      if (k == 5) chk("D refetch mem_a T+5", mem_a, 32'h1040);
      if (inst_valid) vcnt++;
    end
    chk("D early inst_valid count", vcnt, 0);
    next_cyc(); @(negedge clk); chk("D inst_valid T+10", {31'h0, inst_valid}, 1);
    inst_req = 0;

    // E: rdy_in low for 3 cycles after the first IO byte is issued
    poke(10'h000, 8'h7E);
    next_cyc(); data_req = 1; data_wr = 0; data_addr = 32'h30000; data_len = 2'b00;
    next_cyc(); @(negedge clk); chk("E mem_a T+1", mem_a, 32'h30000);
    for (int k = 2; k <= 4; k++) begin
      next_cyc(); rdy_in = 0; @(negedge clk);
      chk($sformatf("E mem_wr paused T+%0d", k), {31'h0, mem_wr}, 0);
      chk($sformatf("E data_valid paused T+%0d", k), {31'h0, data_valid}, 0);
    end
    next_cyc(); rdy_in = 1; @(negedge clk); chk("E reissue mem_a T+5", mem_a, 32'h30000);
    next_cyc(); @(negedge clk); chk("E data_valid T+6", {31'h0, data_valid}, 0);
    next_cyc(); @(negedge clk); chk("E data_valid T+7", {31'h0, data_valid}, 1);
    chk("E data_rdata", data_rdata, 32'h0000007E);
    data_req = 0;

    // F: reset during the second byte of a word store
    next_cyc(); data_req = 1; data_wr = 1; data_addr = 32'h100; data_len = 2'b10;
    data_wdata = 32'h0A0B0C0D;
    next_cyc();
    next_cyc(); rst_in = 0; data_req = 0;
    next_cyc(); rst_in = 1; @(negedge clk);
    chk("F mem_a", mem_a, 0); chk("F mem_dout", {24'h0, mem_dout}, 0);
    chk("F mem_wr", {31'h0, mem_wr}, 0); chk("F busy", {31'h0, busy}, 0);
    chk("F inst_valid", {31'h0, inst_valid}, 0); chk("F data_valid", {31'h0, data_valid}, 0);
    chk("F inst_data", inst_data, 0); chk("F data_rdata", data_rdata, 0);
    vcnt = 0;
    repeat (6) begin next_cyc(); @(negedge clk); if (data_valid) vcnt++; end
    chk("F no data_valid after reset", vcnt, 0);

    // Table of back-to-back transactions with fixed latencies
    for (int i = 0; i < 12; i++) begin
      run_txn(vt[i].is_inst, vt[i].wr, vt[i].addr, vt[i].len, vt[i].wd, 0, rd, lat, pz, rn, ok);
      if (ok) begin
        chk($sformatf("tbl%0d latency", i), lat, vt[i].exp_lat);
        if (!vt[i].wr) chk($sformatf("tbl%0d rdata", i), rd, vt[i].exp_rd);
      end
    end

    // Random traffic with random pauses against a byte-array memory model
    do_init_ram();
    for (int i = 0; i < 1024; i++) mdl[i] = 8'(i * 7 + 3);
    for (int t = 0; t < 150; t++) begin
      is_inst = ($urandom_range(0, 3) == 0);
      wr      = !is_inst && ($urandom_range(0, 1) == 1);
      addr    = 32'($urandom_range(0, 1023));
      len     = 2'($urandom_range(0, 3));
      wd      = $urandom;
      n       = is_inst ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
      expv    = '0;
      for (int b = 0; b < n; b++) expv[8*b +: 8] = mdl[(int'(addr) + b) % 1024];
      run_txn(is_inst, wr, addr, len, wd, 1, rd, lat, pz, rn, ok);
      if (ok) begin
        if (wr) for (int b = 0; b < n; b++) mdl[(int'(addr) + b) % 1024] = wd[8*b +: 8];
        else chk($sformatf("rnd%0d rdata", t), rd, expv);
        base = is_inst ? 6 : wr ? n + 1 : n + 2;
        if (pz == 0) chk($sformatf("rnd%0d latency", t), lat, base);
        else chk($sformatf("rnd%0d stretched latency %0d", t, lat),
                 {31'h0, (lat >= base + pz) && (lat <= base + pz + rn)}, 1);
      end
    end
    rdy_in = 1;
    next_cyc();
    chk("mem_wr while paused", bad_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM/IO bus. Shares the bus between the instruction-fetch port (word reads) and the MEM-stage data port (1/2/4-byte reads and writes). Serialises each request into byte accesses, assembles read bytes little-endian, and drives the raw RAM pins. Sits between IF/MEM and the top-level `mem_*` ports, and is paused by `rdy_in`.

## Interface
- ADDR_W, 32, address width of all address ports.
- IO_SEL, 2'b11, value of `addr[17:16]` that marks the IO region.
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-low reset.
- rdy_in  in  1  when low, the block is paused.
- inst_req  in  1  fetch request; held stable until `inst_valid` or flush.
- inst_addr  in  ADDR_W  fetch address (word).
- inst_flush  in  1  branch redirect; aborts any fetch.
- inst_valid  out  1  one-cycle pulse: `inst_data` is valid.
- inst_data  out  32  fetched word.
- data_req  in  1  data request; held stable until `data_valid`.
- data_wr  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  byte address.
- data_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- data_wdata  in  32  store data; bytes are taken from the LSB up.
- data_valid  out  1  one-cycle pulse: store done or `data_rdata` valid.
- data_rdata  out  32  load data, zero-extended (sign extension is done by MEM).
- busy  out  1  high when state ≠ IDLE.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM address.
- mem_wr  out  1  1 = write.

## Operation
- FSM states: IDLE, INST_RD, DATA_RD, DATA_WR.
- Acceptance happens only in IDLE.
  - `data_req` has priority over `inst_req`.
  - The accept cycle latches the address, length, write data and direction.
- Counters (3 bits each, values 0..4):
  - `issue` counts bytes whose address has been presented.
  - `got` counts bytes captured.
  - N = 4 for INST_RD; for data, N is decoded from `data_len`.
- READ:
  - Present `mem_a = base + issue` while `issue < N`.
  - Capture `mem_din` into byte lane `got` on the cycle after each issue.
  - Done when `got == N`.
- WRITE:
  - Present `mem_a = base + issue`, `mem_dout` = byte `issue`, `mem_wr = 1`.
  - Done when `issue == N`.
- On done: pulse the matching `*_valid` and return to IDLE in the same cycle.
- `inst_flush`:
  - In INST_RD: stop issuing, discard captured and in-flight bytes, suppress `inst_valid` (including a same-cycle valid), go to IDLE next cycle.
  - In IDLE: `inst_req` is not accepted that cycle.
  - Data transfers ignore it.
- `rdy_in` low:
  - All registers hold and `mem_wr` is forced to 0.
  - On resume, set `issue := got`, so the in-flight read byte is re-presented. Each IO byte (0x30000) is therefore consumed exactly once.
- Address arithmetic is modulo 2^ADDR_W. An unaligned multi-byte access simply walks consecutive bytes.
- The inst port never targets the IO region. This is not checked.
- When not issuing: `mem_wr = 0`, and `mem_a` and `mem_dout` hold their last values.

## Timing
- Accept in cycle T; the first address is presented in T+1.
- N-byte read:
  - Addresses presented in T+1..T+N.
  - Bytes captured at the ends of T+2..T+N+1.
  - `*_valid` is high in T+N+2, and a new request can be accepted in that same cycle.
- N-byte write: bytes written in T+1..T+N; `data_valid` is high in T+N+1.
- Word fetch: valid at T+6. Byte store: valid at T+2.
- Reset values: state = IDLE, counters 0, `mem_a` 0, `mem_dout` 0, `mem_wr` 0, `inst_valid` 0, `data_valid` 0, `inst_data` 0, `data_rdata` 0, `busy` 0.
- Reset mid-transfer: the transfer is abandoned and no valid pulse is produced.
- `rdy_in` low stretches all latencies cycle-for-cycle. One extra re-issue cycle is added if a read byte was in flight.

## Structure
- Shared defines (`defines.v`): state encodings, `data_len` encodings, IO_SEL and the IO addresses 0x30000 and 0x30004.
- One sub-module is natural: `mem_rd_assembler`, which holds the byte-lane register, performs lane-select capture and does zero-extension by N.

## Test plan
- Word fetch at 0x1000 with RAM bytes 0x13, 0x05, 0x10, 0x00 → `inst_valid` at T+6 with `inst_data` = 0x00100513, and `mem_a` = 0x1000..0x1003 in T+1..T+4.
- `data_req` and `inst_req` in the same IDLE cycle: store word 0xDEADBEEF to 0x200 → bytes EF, BE, AD, DE with `mem_wr` = 1 in T+1..T+4; `data_valid` at T+5; the fetch is accepted at T+5.
- Half load from 0x301 with bytes 0x80, 0xFF → `data_rdata` = 0x0000FF80 and `data_valid` at T+4.
- `inst_flush` asserted in T+3 of a fetch → no `inst_valid`, no further `mem_a` issue, IDLE at T+4, and a new fetch is accepted at T+4.
- `rdy_in` low for 3 cycles after the first byte is issued on a byte load from 0x30000 → `mem_wr` stays 0, address 0x30000 is re-presented once on resume, exactly one byte is captured, and `data_valid` is delayed by 4 cycles.
- `rst_in` low during DATA_WR byte 2 → next cycle all outputs are at reset values and no `data_valid` is produced.
